// File: rtl/vga_pkg.sv
// Shared definitions for the character text path: command codes,
// text screen geometry and the built-in glyph generator.
package vga_pkg;

    typedef enum logic [1:0] {
        PUT_CHAR   = 2'b00,
        SET_CURSOR = 2'b01,
        CLEAR      = 2'b10,
        NEWLINE    = 2'b11
    } wr_cmd_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } txt_state_e;

    localparam int TEXT_COLS = 16;
    localparam int TEXT_ROWS = 16;
    localparam logic [7:0] FILL_CHAR = 8'h20;
    localparam int FONT_LINES = 16;

    // Glyph row for address {code, line}; the blank code has no pixels.
    function automatic logic [7:0] font_glyph(input logic [11:0] addr);
        logic [7:0] code;
        logic [3:0] line;
        code = addr[11:4];
        line = addr[3:0];
        if (code == FILL_CHAR) begin
            return 8'h00;
        end
        return code ^ {line, ~line};
    endfunction

endpackage

// File: rtl/char_text_buffer_font_rom.sv
// 4096x8 synchronous font ROM addressed by {code, line}.
// Output register clears to zero on reset.
module font_rom
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] addr,
    output logic [7:0]  data
);

    logic [7:0] data_d;
    logic [7:0] data_q;

    always_comb begin
        data_d = font_glyph(addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/char_text_buffer.sv
// 16x16 character screen with cursor writes, clear sequencer and a
// two-cycle glyph lookup path for the text renderer.
module char_text_buffer #(
    parameter int         COLS      = vga_pkg::TEXT_COLS,
    parameter int         ROWS      = vga_pkg::TEXT_ROWS,
    parameter logic [7:0] FILL_CHAR = vga_pkg::FILL_CHAR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_cmd,
    input  logic [7:0] wr_char,
    input  logic [7:0] wr_addr,
    input  logic [7:0] char_xy,
    input  logic [3:0] char_line,
    output logic [7:0] char_pixels,
    output logic [7:0] cursor,
    output logic       busy
);

    import vga_pkg::*;

    txt_state_e state_d, state_q;
    logic [7:0] clr_cnt_d, clr_cnt_q;
    logic [7:0] cursor_d, cursor_q;
    logic       wr_ready_d, wr_ready_q;
    logic       busy_d, busy_q;
    logic [3:0] line_d, line_q;

    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [7:0] code_q;
    logic [7:0] ram [256];

    logic       wr_fire;
    wr_cmd_e    cmd;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] row_inc;

    assign wr_fire = wr_valid && wr_ready_q && (state_q == ST_IDLE);
    assign cmd     = wr_cmd_e'(wr_cmd);
    assign col     = cursor_q[3:0];
    assign row     = cursor_q[7:4];
    assign row_inc = (row == 4'(ROWS - 1)) ? 4'h0 : row + 4'd1;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        cursor_d   = cursor_q;
        wr_ready_d = wr_ready_q;
        busy_d     = busy_q;
        ram_we     = 1'b0;
        ram_waddr  = clr_cnt_q;
        ram_wdata  = FILL_CHAR;
        line_d     = char_line;

        unique case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) begin
                    state_d    = ST_IDLE;
                    cursor_d   = 8'h00;
                    busy_d     = 1'b0;
                    wr_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                wr_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (wr_fire) begin
                    unique case (cmd)
                        PUT_CHAR: begin
                            ram_we    = 1'b1;
                            ram_waddr = cursor_q;
                            ram_wdata = wr_char;
                            if (col == 4'(COLS - 1)) begin
                                cursor_d = {row_inc, 4'h0};
                            end else begin
                                cursor_d = {row, col + 4'd1};
                            end
                        end
                        SET_CURSOR: begin
                            cursor_d = wr_addr;
                        end
                        CLEAR: begin
                            // ready must drop on the very next cycle
                            state_d    = ST_CLEAR;
                            clr_cnt_d  = 8'h00;
                            wr_ready_d = 1'b0;
                            busy_d     = 1'b1;
                        end
                        NEWLINE: begin
                            cursor_d = {row_inc, 4'h0};
                        end
                        default: begin
                            cursor_d = cursor_q;
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= 8'h00;
            cursor_q   <= 8'h00;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            line_q     <= 4'h0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            cursor_q   <= cursor_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            line_q     <= line_d;
        end
    end

    // Text RAM is not reset; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        code_q <= ram[char_xy];
    end

    font_rom u_font_rom (
        .clk   (clk),
        .rst_n (rst),
        .addr  ({code_q, line_q}),
        .data  (char_pixels)
    );

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign cursor   = cursor_q;

endmodule
